// File: rtl/matvec_pkg.sv
// Shared constants and FSM encoding for the 2x2 inverse-matrix / vector multiply block.
// Data words are Q2.14 two's complement.
package matvec_pkg;

  localparam int DW    = 16;
  localparam int FRAC  = 14;
  localparam int Q_ONE = 16384;
  localparam int Q_MAX = 32767;
  localparam int Q_MIN = -32768;

  typedef enum logic [2:0] {
    NOCOEF,
    READY,
    MUL0,
    MAC0,
    MUL1,
    MAC1,
    OUT
  } state_e;

endpackage

// File: rtl/matvec_apply_if.sv
// Handshake bundle for matvec_apply: coefficient load, vector input and result output.
// The master side drives coefficients, vectors and out_ready; the slave side is the block.
interface matvec_apply_if #(
  parameter int DW = 16
);

  logic                 coef_valid;
  logic                 coef_ready;
  logic signed [DW-1:0] a_inv;
  logic signed [DW-1:0] b_inv;
  logic signed [DW-1:0] c_inv;
  logic signed [DW-1:0] d_inv;
  logic                 inv_error;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x0;
  logic signed [DW-1:0] x1;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] y0;
  logic signed [DW-1:0] y1;
  logic                 out_err;
  logic                 out_sat;

  modport master (
    output coef_valid, a_inv, b_inv, c_inv, d_inv, inv_error,
    output in_valid, x0, x1, out_ready,
    input  coef_ready, in_ready, out_valid, y0, y1, out_err, out_sat
  );

  modport slave (
    input  coef_valid, a_inv, b_inv, c_inv, d_inv, inv_error,
    input  in_valid, x0, x1, out_ready,
    output coef_ready, in_ready, out_valid, y0, y1, out_err, out_sat
  );

endinterface

// File: rtl/matvec_apply_q_round_sat.sv
// Converts an exact 2*DW+1 bit Q4.28-style accumulator back to a Q2.14 word:
// add half an LSB, arithmetic shift by FRAC (half rounds toward +inf), then clamp.
module q_round_sat #(
  parameter int DW   = 16,
  parameter int FRAC = 14
) (
  input  logic signed [2*DW:0]  acc_i,
  output logic signed [DW-1:0]  y_o,
  output logic                  sat_o
);

  // One guard bit so the rounding bias can never wrap the accumulator.
  localparam int AW = 2*DW + 2;
  localparam logic signed [AW-1:0] MAX_W = AW'((2**(DW-1)) - 1);
  localparam logic signed [AW-1:0] MIN_W = AW'(-(2**(DW-1)));

  logic signed [AW-1:0] biased;
  logic signed [AW-1:0] shifted;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    biased  = {acc_i[2*DW], acc_i} + AW'(1 << (FRAC-1));
    shifted = biased >>> FRAC;
    y_o     = shifted[DW-1:0];
    sat_o   = 1'b0;
    if (shifted > MAX_W) begin
      y_o   = MAX_W[DW-1:0];
      sat_o = 1'b1;
    end else if (shifted < MIN_W) begin
      y_o   = MIN_W[DW-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/matvec_apply.sv
// y = A_inv * x for a 2x2 Q2.14 inverse matrix, computed over four cycles on one shared
// multiplier. A coefficient set arriving with a vector is parked until that vector's result leaves.
module matvec_apply #(
  parameter int DW   = matvec_pkg::DW,
  parameter int FRAC = matvec_pkg::FRAC
) (
  input  logic           clk,
  input  logic           reset,
  matvec_apply_if.slave  bus
);

  import matvec_pkg::*;

  state_e state_q, state_d;

  logic [3:0][DW-1:0]    coef_q, pend_q, coef_in;
  logic                  err_q, pend_err_q, pend_vld_q;
  logic signed [DW-1:0]  x0_q, x1_q, y0_q, y1_q;
  logic                  out_err_q, out_sat_q;
  logic signed [2*DW:0]  acc_q, acc_d;

  logic signed [DW-1:0]   mul_a, mul_b;
  logic signed [2*DW-1:0] prod;
  logic signed [DW-1:0]   rs_y;
  logic                   rs_sat;
  logic                   coef_fire, in_fire, out_fire;

  assign bus.coef_ready = (state_q == NOCOEF) || (state_q == READY);
  assign bus.in_ready   = (state_q == READY);
  assign bus.out_valid  = (state_q == OUT);
  assign bus.y0         = y0_q;
  assign bus.y1         = y1_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_sat    = out_sat_q;

  assign coef_fire = bus.coef_valid && bus.coef_ready;
  assign in_fire   = bus.in_valid   && bus.in_ready;
  assign out_fire  = bus.out_valid  && bus.out_ready;
  assign coef_in   = {bus.d_inv, bus.c_inv, bus.b_inv, bus.a_inv};

  // Operand select for the single shared multiplier.
  always_comb begin
    mul_a = coef_q[0];
    mul_b = x0_q;
    unique case (state_q)
      MAC0:    begin mul_a = coef_q[1]; mul_b = x1_q; end
      MUL1:    begin mul_a = coef_q[2]; mul_b = x0_q; end
      MAC1:    begin mul_a = coef_q[3]; mul_b = x1_q; end
      default: ;
    endcase
  end

  assign prod = mul_a * mul_b;

  always_comb begin
    acc_d = acc_q;
    unique case (state_q)
      MUL0, MUL1: acc_d = {prod[2*DW-1], prod};
      MAC0, MAC1: acc_d = acc_q + {prod[2*DW-1], prod};
      default:    ;
    endcase
  end

  q_round_sat #(.DW(DW), .FRAC(FRAC)) u_round_sat (
    .acc_i (acc_d),
    .y_o   (rs_y),
    .sat_o (rs_sat)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NOCOEF:  if (coef_fire) state_d = READY;
      READY:   if (in_fire)   state_d = err_q ? OUT : MUL0;
      MUL0:    state_d = MAC0;
      MAC0:    state_d = MUL1;
      MUL1:    state_d = MAC1;
      MAC1:    state_d = OUT;
      OUT:     if (out_fire)  state_d = READY;
      default: state_d = NOCOEF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= NOCOEF;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coef_q     <= '0;
      pend_q     <= '0;
      err_q      <= 1'b0;
      pend_err_q <= 1'b0;
      pend_vld_q <= 1'b0;
      x0_q       <= '0;
      x1_q       <= '0;
      acc_q      <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      out_err_q  <= 1'b0;
      out_sat_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;

      // A set loaded alongside a vector must not disturb that vector's computation.
      if (coef_fire && in_fire) begin
        pend_q     <= coef_in;
        pend_err_q <= bus.inv_error;
        pend_vld_q <= 1'b1;
      end else if (coef_fire) begin
        coef_q <= coef_in;
        err_q  <= bus.inv_error;
      end else if (out_fire && pend_vld_q) begin
        coef_q     <= pend_q;
        err_q      <= pend_err_q;
        pend_vld_q <= 1'b0;
      end

      if (in_fire) begin
        x0_q      <= bus.x0;
        x1_q      <= bus.x1;
        out_err_q <= err_q;
        if (err_q) begin
          y0_q      <= '0;
          y1_q      <= '0;
          out_sat_q <= 1'b0;
        end
      end

      if (state_q == MAC0) begin
        y0_q      <= rs_y;
        out_sat_q <= rs_sat;
      end
      if (state_q == MAC1) begin
        y1_q      <= rs_y;
        out_sat_q <= out_sat_q | rs_sat;
      end
    end
  end

endmodule

// File: tb/tb_matvec_apply.sv
// Randomized and directed bench for matvec_apply against a plain-arithmetic reference model.
module tb_matvec_apply;

  import matvec_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matvec_apply_if #(.DW(DW)) vif ();

  matvec_apply dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference coefficient set currently in effect.
  longint m_a, m_b, m_c, m_d;
  bit     m_err;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // round(acc / 2^FRAC) with ties toward +inf, then clamp to the Q2.14 range.
  function automatic longint q_conv(input longint acc, output bit sat);
    longint n, q;
    n = acc + Q_ONE / 2;
    q = n / Q_ONE;
    if ((n % Q_ONE) != 0 && n < 0) q = q - 1;
    sat = 1'b0;
    if (q > Q_MAX) begin q = Q_MAX; sat = 1'b1; end
    if (q < Q_MIN) begin q = Q_MIN; sat = 1'b1; end
    return q;
  endfunction

  task automatic model(input longint x0, input longint x1,
                       output longint y0, output longint y1, output bit err, output bit sat);
    bit s0, s1;
    err = m_err;
    if (m_err) begin
      y0 = 0; y1 = 0; sat = 1'b0;
    end else begin
      y0  = q_conv(m_a * x0 + m_b * x1, s0);
      y1  = q_conv(m_c * x0 + m_d * x1, s1);
      sat = s0 | s1;
    end
  endtask

  function automatic longint rnd_word();
    logic signed [15:0] v;
    if ($urandom_range(1, 0) == 1) v = 16'($urandom);
    else                           v = 16'($urandom_range(40000, 0) - 20000);
    return longint'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coef(input longint a, input longint b, input longint c, input longint d, input bit err);
    int n;
    vif.coef_valid = 1'b1;
    vif.a_inv = 16'(a); vif.b_inv = 16'(b); vif.c_inv = 16'(c); vif.d_inv = 16'(d);
    vif.inv_error = err;
    n = 0;
    while (vif.coef_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("coef_ready_wait", vif.coef_ready, 1);
    tick();
    vif.coef_valid = 1'b0;
    m_a = a; m_b = b; m_c = c; m_d = d; m_err = err;
  endtask

  // One vector transaction; optionally a new set is offered in the same cycle.
  task automatic apply_vec(input longint x0, input longint x1, input int hold,
                           input longint ey0, input longint ey1, input bit eerr, input bit esat,
                           input bit with_coef, input longint na, input longint nb,
                           input longint nc, input longint nd, input bit nerr);
    int n, lat;
    bit stable, saw_in_ready;
    logic signed [15:0] h0, h1;
    vif.in_valid = 1'b1;
    vif.x0 = 16'(x0); vif.x1 = 16'(x1);
    if (with_coef) begin
      vif.coef_valid = 1'b1;
      vif.a_inv = 16'(na); vif.b_inv = 16'(nb); vif.c_inv = 16'(nc); vif.d_inv = 16'(nd);
      vif.inv_error = nerr;
    end
    n = 0;
    while (vif.in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("in_ready_wait", vif.in_ready, 1);
    if (with_coef) check("coef_ready_with_vec", vif.coef_ready, 1);
    tick();
    vif.in_valid   = 1'b0;
    vif.coef_valid = 1'b0;
    if (with_coef) begin
      m_a = na; m_b = nb; m_c = nc; m_d = nd; m_err = nerr;
    end
    lat = 1;
    while (vif.out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
    check("latency", lat, eerr ? 1 : 5);
    check("y0", $signed(vif.y0), ey0);
    check("y1", $signed(vif.y1), ey1);
    check("out_err", vif.out_err, eerr);
    check("out_sat", vif.out_sat, esat);
    if (hold > 0) begin
      stable = 1'b1; saw_in_ready = 1'b0;
      h0 = vif.y0; h1 = vif.y1;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (vif.out_valid !== 1'b1 || vif.y0 !== h0 || vif.y1 !== h1 ||
            vif.out_err !== eerr || vif.out_sat !== esat) stable = 1'b0;
        if (vif.in_ready !== 1'b0) saw_in_ready = 1'b1;
      end
      check("hold_stable", stable, 1);
      check("hold_in_ready", saw_in_ready, 0);
    end
    vif.out_ready = 1'b1;
    tick();
    vif.out_ready = 1'b0;
    check("out_xfer", vif.out_valid, 0);
    check("back_to_ready", vif.in_ready, 1);
  endtask

  task automatic run_model_vec(input longint x0, input longint x1, input int hold);
    longint ey0, ey1;
    bit eerr, esat;
    model(x0, x1, ey0, ey1, eerr, esat);
    apply_vec(x0, x1, hold, ey0, ey1, eerr, esat, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    bit saw_out, saw_in;
    longint ey0, ey1;
    bit eerr, esat;

    vif.coef_valid = 1'b0; vif.inv_error = 1'b0;
    vif.a_inv = '0; vif.b_inv = '0; vif.c_inv = '0; vif.d_inv = '0;
    vif.in_valid = 1'b0; vif.x0 = '0; vif.x1 = '0; vif.out_ready = 1'b0;
    m_a = 0; m_b = 0; m_c = 0; m_d = 0; m_err = 1'b0;

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_out_valid", vif.out_valid, 0);
    check("rst_out_err", vif.out_err, 0);
    check("rst_out_sat", vif.out_sat, 0);
    check("rst_in_ready", vif.in_ready, 0);
    check("rst_coef_ready", vif.coef_ready, 1);
    check("rst_y0", $signed(vif.y0), 0);

    // Identity
    load_coef(16384, 0, 0, 16384, 1'b0);
    apply_vec(8192, -4096, 0, 8192, -4096, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

    // Rotation-like set
    load_coef(16384, 8192, -8192, 16384, 1'b0);
    apply_vec(16384, 16384, 0, 24576, 8192, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

    // Both rows saturate, in opposite directions
    load_coef(32767, 32767, -32768, -32768, 1'b0);
    apply_vec(32767, 32767, 0, 32767, -32768, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);

    // Singular set
    load_coef(1234, -77, 500, 9, 1'b1);
    apply_vec(rnd_word(), rnd_word(), 0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

    // Back-pressure for 10 cycles
    load_coef(16384, 0, 0, 16384, 1'b0);
    apply_vec(-3000, 12345, 10, -3000, 12345, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

    // New set loaded together with a vector applies to the following vector only
    apply_vec(1000, -2000, 0, 1000, -2000, 1'b0, 1'b0, 1'b1, 16384, 8192, -8192, 16384, 1'b0);
    apply_vec(16384, 16384, 0, 24576, 8192, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

    // Rounding ties: +0.5 LSB rounds up, -0.5 LSB rounds toward +inf too
    load_coef(1, 0, 0, -1, 1'b0);
    apply_vec(8192, 8192, 0, 1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(9, 0) < 3)
        load_coef(rnd_word(), rnd_word(), rnd_word(), rnd_word(), $urandom_range(9, 0) == 0);
      run_model_vec(rnd_word(), rnd_word(), int'($urandom_range(3, 0)));
    end

    // Reset during MAC0 aborts the computation
    load_coef(16384, 0, 0, 16384, 1'b0);
    vif.in_valid = 1'b1; vif.x0 = 16'(100); vif.x1 = 16'(200);
    check("abort_in_ready", vif.in_ready, 1);
    tick();
    vif.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_state", longint'(dut.state_q), longint'(NOCOEF));
    check("abort_coef_ready", vif.coef_ready, 1);
    saw_out = 1'b0; saw_in = 1'b0;
    vif.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (vif.out_valid !== 1'b0) saw_out = 1'b1;
      if (vif.in_ready  !== 1'b0) saw_in  = 1'b1;
      tick();
    end
    vif.in_valid = 1'b0;
    check("abort_no_out", saw_out, 0);
    check("abort_vec_refused", saw_in, 0);
    load_coef(16384, 16384, 0, 16384, 1'b0);
    model(300, -100, ey0, ey1, eerr, esat);
    apply_vec(300, -100, 0, ey0, ey1, eerr, esat, 1'b0, 0, 0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
